// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer for the dzcpu core.
//   Accepts opcode bytes from fetch, loads the micro-PC from external main/CB
//   dispatch LUTs, steps an external combinational microcode ROM and decodes
//   each word's next-control field into PC-increment, flag-update and
//   end-of-flow strobes. Handles stalls, conditional end-of-flow, CB-page
//   redispatch and sticky error detection.
//
// Optional feature: define DZCPU_USEQ_RETIRE_CNT_EN to add oRetireCnt, a
// 16-bit wrapping count of oEof pulses.
//
// Ports:
//   iClock, iReset          clock, synchronous active-high reset
//   iMop/iMopValid/oMopReady opcode byte handshake from fetch
//   iMainIdx, iCbIdx        main / CB page flow index from external LUTs
//   oUaddr, iUop            microcode ROM address and returned word
//   oUop, oUopValid         body field to datapath and its execute strobe
//   iStall                  freezes the sequencer
//   iFlagZ                  Z flag for conditional end-of-flow
//   oPcInc, oFlagUpd, oEof  per-uop strobes
//   oBadNext, oUpcOvf       sticky error flags (cleared only by reset)
//   oRetireCnt              retired-opcode count (optional)
module dzcpu_useq #(
  parameter int unsigned MOP_W  = 8,
  parameter int unsigned UPC_W  = 8,
  parameter int unsigned UOP_W  = 12,
  parameter int unsigned NEXT_W = 4
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic [MOP_W-1:0]        iMop,
  input  logic                    iMopValid,
  output logic                    oMopReady,
  input  logic [UPC_W-1:0]        iMainIdx,
  input  logic [UPC_W-1:0]        iCbIdx,
  output logic [UPC_W-1:0]        oUaddr,
  input  logic [UOP_W-1:0]        iUop,
  output logic [UOP_W-NEXT_W-1:0] oUop,
  output logic                    oUopValid,
  input  logic                    iStall,
  input  logic                    iFlagZ,
  output logic                    oPcInc,
  output logic                    oFlagUpd,
  output logic                    oEof,
  output logic                    oBadNext,
  output logic                    oUpcOvf
`ifdef DZCPU_USEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]             oRetireCnt
`endif
);

  typedef enum logic [1:0] {StFetch, StRun, StCbWait} state_e;

  state_e             r_st;
  logic [UPC_W-1:0]   r_upc;
  logic               r_bad_next;
  logic               r_upc_ovf;

  state_e             w_st_d;
  logic [UPC_W-1:0]   w_upc_d;
  logic [NEXT_W-1:0]  w_next;
  logic               w_upc_max;
  logic               w_ready;
  logic               w_uop_valid;
  logic               w_pc_inc;
  logic               w_flag_upd;
  logic               w_eof;
  logic               w_adv;
  logic               w_bad;
  logic               w_ovf;
  logic               w_run;

  // The opcode itself is consumed only by the external dispatch LUTs.
  logic               w_unused;
  assign w_unused = ^iMop;

  assign w_next    = iUop[UOP_W-1 -: NEXT_W];
  assign w_upc_max = (r_upc == {UPC_W{1'b1}});
  assign w_run     = (r_st == StRun);

  always_comb begin
    w_ready     = 1'b0;
    w_uop_valid = 1'b0;
    w_pc_inc    = 1'b0;
    w_flag_upd  = 1'b0;
    w_eof       = 1'b0;
    w_adv       = 1'b0;
    w_bad       = 1'b0;
    w_ovf       = 1'b0;
    w_st_d      = r_st;
    w_upc_d     = r_upc;
    unique case (r_st)
      StFetch: begin
        w_ready = 1'b1;
        if (iMopValid) begin
          w_upc_d = iMainIdx;
          w_st_d  = StRun;
        end
      end
      StRun: begin
        // A stalled uop freezes everything; its strobes fire on the first
        // unstalled cycle.
        if (!iStall) begin
          w_uop_valid = 1'b1;
          case (w_next)
            NEXT_W'(0): w_adv = 1'b1;
            NEXT_W'(1): begin
              w_adv    = 1'b1;
              w_pc_inc = 1'b1;
            end
            NEXT_W'(2): w_eof = 1'b1;
            NEXT_W'(3): begin
              w_pc_inc = 1'b1;
              w_eof    = 1'b1;
            end
            NEXT_W'(4): begin
              w_flag_upd = 1'b1;
              w_eof      = 1'b1;
            end
            NEXT_W'(5): begin
              w_pc_inc   = 1'b1;
              w_flag_upd = 1'b1;
              w_eof      = 1'b1;
            end
            NEXT_W'(6): begin
              w_pc_inc = 1'b1;
              w_eof    = iFlagZ;
              w_adv    = ~iFlagZ;
            end
            NEXT_W'(7): begin
              w_pc_inc = 1'b1;
              w_st_d   = StCbWait;
            end
            default: begin
              w_adv = 1'b1;
              w_bad = 1'b1;
            end
          endcase
          if (w_eof) begin
            // Park uPC at 0 while idle.
            w_st_d  = StFetch;
            w_upc_d = '0;
          end else if (w_adv) begin
            // No wrap at the top of the ROM: hold and flag instead.
            if (w_upc_max) begin
              w_ovf = 1'b1;
            end else begin
              w_upc_d = r_upc + UPC_W'(1);
            end
          end
        end
      end
      StCbWait: begin
        w_ready = 1'b1;
        if (iMopValid) begin
          w_upc_d = iCbIdx;
          w_st_d  = StRun;
        end
      end
      default: w_st_d = StFetch;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_st       <= StFetch;
      r_upc      <= '0;
      r_bad_next <= 1'b0;
      r_upc_ovf  <= 1'b0;
    end else begin
      r_st  <= w_st_d;
      r_upc <= w_upc_d;
      if (w_bad) r_bad_next <= 1'b1;
      if (w_ovf) r_upc_ovf <= 1'b1;
    end
  end

  // Every output is forced low while reset is held.
  assign oMopReady = w_ready & ~iReset;
  assign oUaddr    = iReset ? '0 : r_upc;
  assign oUop      = (w_run && !iReset) ? iUop[UOP_W-NEXT_W-1:0] : '0;
  assign oUopValid = w_uop_valid & ~iReset;
  assign oPcInc    = w_pc_inc & ~iReset;
  assign oFlagUpd  = w_flag_upd & ~iReset;
  assign oEof      = w_eof & ~iReset;
  assign oBadNext  = r_bad_next & ~iReset;
  assign oUpcOvf   = r_upc_ovf & ~iReset;

`ifdef DZCPU_USEQ_RETIRE_CNT_EN
  logic [15:0] r_retire_cnt;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_retire_cnt <= '0;
    end else if (w_eof) begin
      r_retire_cnt <= r_retire_cnt + 16'd1;
    end
  end

  assign oRetireCnt = iReset ? 16'd0 : r_retire_cnt;
`endif

endmodule

// File: tb/tb_dzcpu_useq.sv
// Bench for dzcpu_useq: a table of single-uop decode vectors checked through
// a scoreboard queue, plus hand-written multi-cycle sequences (reset, 1-byte
// flow, stall, conditional eof, CB redispatch, sticky errors).
module tb_dzcpu_useq;

  logic        iClock;
  logic        iReset;
  logic [7:0]  iMop;
  logic        iMopValid;
  logic        oMopReady;
  logic [7:0]  iMainIdx;
  logic [7:0]  iCbIdx;
  logic [7:0]  oUaddr;
  logic [11:0] iUop;
  logic [7:0]  oUop;
  logic        oUopValid;
  logic        iStall;
  logic        iFlagZ;
  logic        oPcInc;
  logic        oFlagUpd;
  logic        oEof;
  logic        oBadNext;
  logic        oUpcOvf;
`ifdef DZCPU_USEQ_RETIRE_CNT_EN
  logic [15:0] oRetireCnt;
  logic [15:0] m_retire;
`endif

  logic [11:0] rom [256];
  assign iUop = rom[oUaddr];

  int n_checks = 0;
  int n_errors = 0;

  dzcpu_useq #(
    .MOP_W (8),
    .UPC_W (8),
    .UOP_W (12),
    .NEXT_W(4)
  ) dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iMop     (iMop),
    .iMopValid(iMopValid),
    .oMopReady(oMopReady),
    .iMainIdx (iMainIdx),
    .iCbIdx   (iCbIdx),
    .oUaddr   (oUaddr),
    .iUop     (iUop),
    .oUop     (oUop),
    .oUopValid(oUopValid),
    .iStall   (iStall),
    .iFlagZ   (iFlagZ),
    .oPcInc   (oPcInc),
    .oFlagUpd (oFlagUpd),
    .oEof     (oEof),
    .oBadNext (oBadNext),
    .oUpcOvf  (oUpcOvf)
`ifdef DZCPU_USEQ_RETIRE_CNT_EN
    ,
    .oRetireCnt(oRetireCnt)
`endif
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

`ifdef DZCPU_USEQ_RETIRE_CNT_EN
  always @(posedge iClock) begin
    if (iReset) m_retire <= 16'd0;
    else if (oEof) m_retire <= m_retire + 16'd1;
  end
`endif

  typedef struct {
    logic [3:0] n;
    logic       z;
    logic [7:0] body;
    logic       pc;
    logic       fu;
    logic       eof;
    logic [7:0] nxt_addr;
    logic       nxt_rdy;
  } vec_t;

  vec_t vecs [11];
  vec_t q_sb [$];
  logic [7:0] exp_t3 [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock; returns at the following negedge where outputs are
  // sampled and new inputs are applied.
  task automatic cyc();
    @(posedge iClock);
    @(negedge iClock);
  endtask

  task automatic start_flow(input logic [7:0] idx);
    iMainIdx  = idx;
    iMopValid = 1'b1;
    cyc();
    iMopValid = 1'b0;
    #1;
  endtask

  // Runs until an eof pulse (bounded); consumes the eof cycle.
  task automatic run_to_eof(input int maxc, output int eof_addr, output int ncyc);
    eof_addr = -1;
    ncyc     = -1;
    for (int c = 0; c < maxc; c++) begin
      if (oEof) begin
        eof_addr = int'(oUaddr);
        ncyc     = c + 1;
        cyc();
        break;
      end
      cyc();
    end
  endtask

  initial begin
    int   ea;
    int   nc;
    int   eof_c;
    logic seen_bad;
    vec_t e;

    // n, z, body, pc, fu, eof, next addr, next ready
    vecs[0]  = '{4'd0,  1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'd41, 1'b0};
    vecs[1]  = '{4'd1,  1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'd41, 1'b0};
    vecs[2]  = '{4'd2,  1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1};
    vecs[3]  = '{4'd3,  1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'd0,  1'b1};
    vecs[4]  = '{4'd4,  1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'd0,  1'b1};
    vecs[5]  = '{4'd5,  1'b0, 8'h66, 1'b1, 1'b1, 1'b1, 8'd0,  1'b1};
    vecs[6]  = '{4'd6,  1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'd0,  1'b1};
    vecs[7]  = '{4'd6,  1'b0, 8'h88, 1'b1, 1'b0, 1'b0, 8'd41, 1'b0};
    vecs[8]  = '{4'd7,  1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 8'd40, 1'b1};
    vecs[9]  = '{4'd0,  1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'd41, 1'b0};
    vecs[10] = '{4'd12, 1'b0, 8'hBB, 1'b0, 1'b0, 1'b0, 8'd41, 1'b0};

    exp_t3 = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4};

    for (int i = 0; i < 256; i++) rom[i] = {4'd2, 8'h00};
    rom[0]   = {4'd3, 8'h01};
    rom[1]   = {4'd1, 8'h10};
    rom[2]   = {4'd0, 8'h20};
    rom[3]   = {4'd0, 8'h30};
    rom[4]   = {4'd3, 8'h40};
    rom[5]   = {4'd9, 8'h50};
    rom[6]   = {4'd2, 8'h60};
    rom[13]  = {4'd1, 8'h13};
    rom[14]  = {4'd0, 8'h14};
    rom[15]  = {4'd7, 8'h15};
    rom[16]  = {4'd4, 8'h16};
    rom[17]  = {4'd1, 8'h17};
    rom[18]  = {4'd0, 8'h18};
    rom[19]  = {4'd6, 8'h19};
    rom[20]  = {4'd0, 8'h20};
    rom[21]  = {4'd0, 8'h21};
    rom[22]  = {4'd2, 8'h22};
    rom[41]  = {4'd2, 8'h41};
    rom[255] = {4'd0, 8'hFF};

    iReset    = 1'b1;
    iMop      = 8'h00;
    iMopValid = 1'b1;
    iMainIdx  = 8'd7;
    iCbIdx    = 8'd9;
    iStall    = 1'b0;
    iFlagZ    = 1'b0;

    // T1: reset held 3 cycles with a valid opcode offered.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_reset_outputs",
          {oMopReady, oUaddr, oUop, oUopValid, oPcInc, oFlagUpd, oEof, oBadNext, oUpcOvf},
          32'd0);
    end
    iReset    = 1'b0;
    iMopValid = 1'b0;
    #1;
    chk("t1_ready_after_release", oMopReady, 1);
    chk("t1_uaddr_after_release", oUaddr, 0);

    // T2: 1-byte flow through index 0.
    start_flow(8'd0);
    chk("t2_uaddr", oUaddr, 0);
    chk("t2_strobes", {oUopValid, oPcInc, oFlagUpd, oEof}, 4'b1101);
    chk("t2_ready_in_run", oMopReady, 0);
    cyc();
    chk("t2_ready_next", oMopReady, 1);

    // Decode table through flow 40 with a scoreboard of expectations.
    seen_bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rom[40]   = {vecs[i].n, vecs[i].body};
      iFlagZ    = vecs[i].z;
      iMainIdx  = 8'd40;
      iMopValid = 1'b1;
      q_sb.push_back(vecs[i]);
      #1;
      chk("tbl_ready_fetch", oMopReady, 1);
      cyc();
      iMopValid = 1'b0;
      #1;
      chk("tbl_uop_valid", oUopValid, 1);
      if (oUopValid && q_sb.size() > 0) begin
        e = q_sb.pop_front();
        chk("tbl_body", oUop, e.body);
        chk("tbl_pcinc", oPcInc, e.pc);
        chk("tbl_flagupd", oFlagUpd, e.fu);
        chk("tbl_eof", oEof, e.eof);
        chk("tbl_badnext", oBadNext, seen_bad);
        if (e.n > 4'd7) seen_bad = 1'b1;
      end else if (q_sb.size() > 0) begin
        e = q_sb.pop_front();
      end
      cyc();
      chk("tbl_next_uaddr", oUaddr, vecs[i].nxt_addr);
      chk("tbl_next_ready", oMopReady, vecs[i].nxt_rdy);
      if (vecs[i].n == 4'd7) begin
        iMop      = 8'h7C;
        iCbIdx    = 8'd41;
        iMopValid = 1'b1;
        cyc();
        iMopValid = 1'b0;
        #1;
        run_to_eof(8, ea, nc);
        chk("tbl_cb_eof_addr", ea, 41);
      end else if (!vecs[i].eof) begin
        run_to_eof(8, ea, nc);
        chk("tbl_drain_eof_addr", ea, 41);
      end
    end
    chk("tbl_badnext_final", oBadNext, 1);
    iFlagZ = 1'b0;

    // T3: stall on the third uop for two cycles.
    start_flow(8'd1);
    eof_c = -1;
    for (int c = 0; c < 10; c++) begin
      iStall = (c == 2) || (c == 3);
      #1;
      if (c < 6) chk("t3_uaddr", oUaddr, exp_t3[c]);
      if (iStall) chk("t3_stall_strobes", {oUopValid, oPcInc, oFlagUpd, oEof}, 0);
      if (oEof) begin
        chk("t3_eof_pcinc", oPcInc, 1);
        eof_c = c;
        cyc();
        break;
      end
      cyc();
    end
    iStall = 1'b0;
    chk("t3_run_cycles", eof_c + 1, 6);

    // T4: conditional end-of-flow.
    iFlagZ = 1'b1;
    start_flow(8'd17);
    run_to_eof(12, ea, nc);
    chk("t4_z1_eof_addr", ea, 19);
    chk("t4_z1_cycles", nc, 3);
    iFlagZ = 1'b0;
    start_flow(8'd17);
    run_to_eof(12, ea, nc);
    chk("t4_z0_eof_addr", ea, 22);
    chk("t4_z0_cycles", nc, 6);

    // T5: CB-page redispatch.
    start_flow(8'd13);
    cyc();
    cyc();
    chk("t5_jcb_uaddr", oUaddr, 15);
    chk("t5_jcb_strobes", {oPcInc, oEof}, 2'b10);
    cyc();
    chk("t5_cbwait", {oMopReady, oUopValid}, 2'b10);
    iMop      = 8'h7C;
    iCbIdx    = 8'd16;
    iMopValid = 1'b1;
    cyc();
    iMopValid = 1'b0;
    #1;
    chk("t5_cb_uaddr", oUaddr, 16);
    chk("t5_cb_strobes", {oPcInc, oFlagUpd, oEof}, 3'b011);
    cyc();

    // T6: sticky errors.
    iReset = 1'b1;
    cyc();
    iReset = 1'b0;
    #1;
    chk("t6_clear", {oBadNext, oUpcOvf}, 0);
    start_flow(8'd5);
    chk("t6_bad_uop_valid", oUopValid, 1);
    cyc();
    chk("t6_bad_uaddr", oUaddr, 6);
    chk("t6_badnext_set", oBadNext, 1);
    cyc();
    chk("t6_badnext_sticky", oBadNext, 1);
    start_flow(8'd255);
    chk("t6_ovf_before", oUpcOvf, 0);
    cyc();
    chk("t6_ovf_set", oUpcOvf, 1);
    chk("t6_ovf_uaddr", oUaddr, 255);
    cyc();
    chk("t6_ovf_hold", {oUaddr, oUpcOvf, oBadNext}, {8'd255, 1'b1, 1'b1});
    iReset = 1'b1;
    cyc();
    chk("t6_reset_midflow",
        {oMopReady, oUaddr, oUop, oUopValid, oPcInc, oFlagUpd, oEof, oBadNext, oUpcOvf},
        32'd0);
    iReset = 1'b0;
    #1;
    chk("t6_after_reset", {oMopReady, oUaddr, oBadNext, oUpcOvf}, {1'b1, 8'd0, 2'b00});

`ifdef DZCPU_USEQ_RETIRE_CNT_EN
    start_flow(8'd0);
    cyc();
    chk("retire_cnt", oRetireCnt, m_retire);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
